// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// Register scoreboard and recovery sequencer for an in-order pipeline.
// For every architectural register it tracks whether a write is still in
// flight (pend) and, for fixed-latency producers, how many cycles remain until
// the result appears on the bypass (cnt). A decode-stage instruction is
// accepted only when none of its operands or its destination collide with an
// in-flight write. When a producer is retiring in the same cycle, its result
// is forwarded instead. Committed exceptions and erets flush the pipe, clear
// the scoreboard and redirect the fetch PC.
//
// Issue handshake: issue_valid means a decoded instruction is offered this
// cycle; issue_ready is high only in a cycle where issue_valid is high and the
// instruction can be taken. The instruction is accepted exactly in the cycles
// where both are high. issue_ready never depends on a later cycle, and an
// offered instruction that is not accepted is expected to be held in decode
// (stallD) and offered again.
//
// Ports
//   clk, resetn                 clock (rising edge), async active-low reset
//   issue_valid                 decode-stage instruction present
//   issue_rs/rt, *_used         source registers and whether each is read
//   issue_wen, issue_wreg       destination write enable and register
//   issue_lat                   cycles to bypass, 0 = variable latency
//   wb_valid, wb_reg            variable-latency completion
//   stall_imem                  instruction memory not ready
//   except_valid, excepttype    exception / eret committed in M
//   epc                         return PC for eret (excepttype 0x0E)
//   issue_ready                 instruction accepted this cycle
//   fwd_rs, fwd_rt              take operand from the bypass this cycle
//   stallF, stallD              hold PC / IF-ID register
//   flush                       per-stage flush, bit0=F .. bit4=W
//   newpc, newpc_valid          fetch redirect
//   dbg_state                   recovery FSM state (0=IDLE, 1=REDIRECT)
//   dbg_pend                    per-register pending bits
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
  parameter int          NREG       = 32,
  parameter int          LAT_W      = 3,
  parameter int          NSTAGE     = 5,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    issue_valid,
  input  logic [$clog2(NREG)-1:0] issue_rs,
  input  logic [$clog2(NREG)-1:0] issue_rt,
  input  logic                    issue_rs_used,
  input  logic                    issue_rt_used,
  input  logic                    issue_wen,
  input  logic [$clog2(NREG)-1:0] issue_wreg,
  input  logic [LAT_W-1:0]        issue_lat,
  input  logic                    wb_valid,
  input  logic [$clog2(NREG)-1:0] wb_reg,
  input  logic                    stall_imem,
  input  logic                    except_valid,
  input  logic [31:0]             excepttype,
  input  logic [31:0]             epc,
  output logic                    issue_ready,
  output logic                    fwd_rs,
  output logic                    fwd_rt,
  output logic                    stallF,
  output logic                    stallD,
  output logic [NSTAGE-1:0]       flush,
  output logic [31:0]             newpc,
  output logic                    newpc_valid,
  output logic                    dbg_state,
  output logic [NREG-1:0]         dbg_pend
);

  localparam int RW = $clog2(NREG);

  typedef enum logic {
    S_IDLE     = 1'b0,
    S_REDIRECT = 1'b1
  } state_t;

  state_t           r_state;
  logic [31:0]      r_newpc;
  logic             r_newpc_valid;
  logic [NREG-1:0]  r_pend;
  logic [LAT_W-1:0] r_cnt [NREG];

  logic [NREG-1:0]  w_retire;
  logic             w_idle;
  logic             w_exc;
  logic             w_raw_rs;
  logic             w_raw_rt;
  logic             w_waw;
  logic             w_hazard;
  logic             w_ready;
  logic             w_fwd_rs;
  logic             w_fwd_rt;

  // An entry is retiring when its result reaches the bypass this cycle:
  // either the fixed-latency count is on its last cycle, or a variable-latency
  // entry sees its writeback. Entry 0 is never pending, so never retires.
  for (genvar g = 0; g < NREG; g++) begin : g_retire
    assign w_retire[g] = r_pend[g] &&
                         ((r_cnt[g] == LAT_W'(1)) ||
                          ((r_cnt[g] == '0) && wb_valid && (wb_reg == RW'(g))));
  end

  assign w_idle = (r_state == S_IDLE);

  // excepttype 0 is not an exception, and a second exception while the
  // redirect is still in progress is dropped.
  assign w_exc  = except_valid && (excepttype != 32'h0) && w_idle;

  // A retiring producer is not a hazard: its value is taken from the bypass.
  assign w_raw_rs = issue_rs_used && (issue_rs != '0) && r_pend[issue_rs] && !w_retire[issue_rs];
  assign w_raw_rt = issue_rt_used && (issue_rt != '0) && r_pend[issue_rt] && !w_retire[issue_rt];
  assign w_waw    = issue_wen && (issue_wreg != '0) && r_pend[issue_wreg] && !w_retire[issue_wreg];

  assign w_hazard = issue_valid && (w_raw_rs || w_raw_rt || w_waw);
  assign w_ready  = issue_valid && !w_raw_rs && !w_raw_rt && !w_waw &&
                    !stall_imem && w_idle && !except_valid;
  assign w_fwd_rs = issue_valid && issue_rs_used && w_retire[issue_rs];
  assign w_fwd_rt = issue_valid && issue_rt_used && w_retire[issue_rt];

  // Combinational outputs are forced quiet while reset is asserted so that
  // nothing downstream reacts to inputs before the block is live.
  assign issue_ready = resetn && w_ready;
  assign fwd_rs      = resetn && w_fwd_rs;
  assign fwd_rt      = resetn && w_fwd_rt;
  assign stallF      = resetn && ((issue_valid && !w_ready) || stall_imem || !w_idle);
  assign stallD      = stallF;

  always_comb begin
    flush = '0;
    if (resetn) begin
      if (w_exc) begin
        flush = '1;
      end else begin
        if (!w_idle) flush[1:0] = 2'b11;
        // Bubble into E while decode is held, unless fetch is stalled anyway.
        if (w_hazard && !stall_imem) flush[2] = 1'b1;
      end
    end
  end

  assign newpc       = r_newpc;
  assign newpc_valid = r_newpc_valid;
  assign dbg_state   = r_state;
  assign dbg_pend    = r_pend;

  // Recovery FSM. newpc_valid is registered alongside the state so it is high
  // for every REDIRECT cycle, including the one in which fetch resumes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= S_IDLE;
      r_newpc       <= '0;
      r_newpc_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_exc) begin
            r_state       <= S_REDIRECT;
            r_newpc       <= (excepttype == 32'h0E) ? epc : EXC_VECTOR;
            r_newpc_valid <= 1'b1;
          end
        end
        S_REDIRECT: begin
          if (!stall_imem) begin
            r_state       <= S_IDLE;
            r_newpc_valid <= 1'b0;
          end
        end
        default: begin
          r_state       <= S_IDLE;
          r_newpc_valid <= 1'b0;
        end
      endcase
    end
  end

  // Scoreboard entries. An accepted write to a register outranks its
  // retirement in the same cycle, so the entry is reloaded rather than
  // cleared. An exception wipes everything, including any writeback that
  // lands in the same cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pend <= '0;
      for (int r = 0; r < NREG; r++) r_cnt[r] <= '0;
    end else if (w_exc) begin
      r_pend <= '0;
      for (int r = 0; r < NREG; r++) r_cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (w_ready && issue_wen && (issue_wreg != '0) && (issue_wreg == RW'(r))) begin
          r_pend[r] <= 1'b1;
          r_cnt[r]  <= issue_lat;
        end else if (w_retire[r]) begin
          r_pend[r] <= 1'b0;
          r_cnt[r]  <= '0;
        end else if (r_pend[r] && (r_cnt[r] > LAT_W'(1))) begin
          r_cnt[r]  <= r_cnt[r] - LAT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        resetn;
  always #5 clk = ~clk;

  logic        issue_valid;
  logic [4:0]  issue_rs, issue_rt;
  logic        issue_rs_used, issue_rt_used;
  logic        issue_wen;
  logic [4:0]  issue_wreg;
  logic [2:0]  issue_lat;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic        stall_imem;
  logic        except_valid;
  logic [31:0] excepttype;
  logic [31:0] epc;
  logic        issue_ready, fwd_rs, fwd_rt, stallF, stallD;
  logic [4:0]  flush;
  logic [31:0] newpc;
  logic        newpc_valid;
  logic        dbg_state;
  logic [31:0] dbg_pend;

  int n_vec = 0;
  int n_err = 0;

  hazard_scoreboard dut (
    .clk          (clk),
    .resetn       (resetn),
    .issue_valid  (issue_valid),
    .issue_rs     (issue_rs),
    .issue_rt     (issue_rt),
    .issue_rs_used(issue_rs_used),
    .issue_rt_used(issue_rt_used),
    .issue_wen    (issue_wen),
    .issue_wreg   (issue_wreg),
    .issue_lat    (issue_lat),
    .wb_valid     (wb_valid),
    .wb_reg       (wb_reg),
    .stall_imem   (stall_imem),
    .except_valid (except_valid),
    .excepttype   (excepttype),
    .epc          (epc),
    .issue_ready  (issue_ready),
    .fwd_rs       (fwd_rs),
    .fwd_rt       (fwd_rt),
    .stallF       (stallF),
    .stallD       (stallD),
    .flush        (flush),
    .newpc        (newpc),
    .newpc_valid  (newpc_valid),
    .dbg_state    (dbg_state),
    .dbg_pend     (dbg_pend)
  );

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic idle_inputs();
    issue_valid = 0; issue_rs = 0; issue_rt = 0; issue_rs_used = 0; issue_rt_used = 0;
    issue_wen = 0; issue_wreg = 0; issue_lat = 0; wb_valid = 0; wb_reg = 0;
    stall_imem = 0; except_valid = 0; excepttype = 0; epc = 0;
  endtask

  // Advance one clock; inputs are changed 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_write(input logic [4:0] wreg, input logic [2:0] lat);
    idle_inputs();
    issue_valid = 1; issue_wen = 1; issue_wreg = wreg; issue_lat = lat;
  endtask

  task automatic drive_use_rs(input logic [4:0] rs);
    idle_inputs();
    issue_valid = 1; issue_rs = rs; issue_rs_used = 1;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    idle_inputs();
    resetn = 1;
    #2 resetn = 0;
    // Busy inputs while in reset must not leak to the outputs.
    issue_valid = 1; issue_rs = 5; issue_rs_used = 1; stall_imem = 1;
    except_valid = 1; excepttype = 32'h0C;
    tick(); tick();
    n_vec++; if (issue_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b exp 0", issue_ready); end
    n_vec++; if (stallF !== 1'b0) begin n_err++; $display("FAIL rst_stallF: got %b exp 0", stallF); end
    n_vec++; if (stallD !== 1'b0) begin n_err++; $display("FAIL rst_stallD: got %b exp 0", stallD); end
    n_vec++; if (flush !== 5'b00000) begin n_err++; $display("FAIL rst_flush: got %b exp 00000", flush); end
    n_vec++; if (newpc !== 32'h0) begin n_err++; $display("FAIL rst_newpc: got %h exp 0", newpc); end
    n_vec++; if (newpc_valid !== 1'b0) begin n_err++; $display("FAIL rst_newpc_valid: got %b exp 0", newpc_valid); end
    n_vec++; if (dbg_state !== 1'b0) begin n_err++; $display("FAIL rst_state: got %b exp 0", dbg_state); end
    n_vec++; if (dbg_pend !== 32'h0) begin n_err++; $display("FAIL rst_pend: got %h exp 0", dbg_pend); end
    idle_inputs();
    #1 resetn = 1;
    tick();
  endtask

  // Fixed latency 3 producer to r5, consumer of r5 on every following cycle.
  task automatic test_fixed_lat();
    drive_write(5'd5, 3'd3);
    #1;
    n_vec++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL fix_issue: got %b exp 1", issue_ready); end
    tick();
    drive_use_rs(5'd5);
    for (int c = 0; c < 2; c++) begin
      #1;
      n_vec++; if (issue_ready !== 1'b0) begin n_err++; $display("FAIL fix_stall_ready c%0d: got %b exp 0", c, issue_ready); end
      n_vec++; if (flush !== 5'b00100) begin n_err++; $display("FAIL fix_bubble c%0d: got %b exp 00100", c, flush); end
      n_vec++; if (stallD !== 1'b1) begin n_err++; $display("FAIL fix_stallD c%0d: got %b exp 1", c, stallD); end
      n_vec++; if (fwd_rs !== 1'b0) begin n_err++; $display("FAIL fix_nofwd c%0d: got %b exp 0", c, fwd_rs); end
      tick();
    end
    #1;
    n_vec++; if (fwd_rs !== 1'b1) begin n_err++; $display("FAIL fix_fwd: got %b exp 1", fwd_rs); end
    n_vec++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL fix_ready: got %b exp 1", issue_ready); end
    n_vec++; if (flush !== 5'b00000) begin n_err++; $display("FAIL fix_noflush: got %b exp 00000", flush); end
    n_vec++; if (stallF !== 1'b0) begin n_err++; $display("FAIL fix_nostall: got %b exp 0", stallF); end
    tick();
    idle_inputs();
    #1;
    n_vec++; if (dbg_pend !== 32'h0) begin n_err++; $display("FAIL fix_cleared: got %h exp 0", dbg_pend); end
  endtask

  // Variable latency producer to r7; consumer on rt waits for wb of r7.
  task automatic test_var_lat();
    drive_write(5'd7, 3'd0);
    #1;
    n_vec++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL var_issue: got %b exp 1", issue_ready); end
    tick();
    idle_inputs();
    issue_valid = 1; issue_rt = 7; issue_rt_used = 1;
    for (int c = 0; c < 3; c++) begin
      // A writeback to another register must not release r7.
      wb_valid = (c == 1); wb_reg = 5'd6;
      #1;
      n_vec++; if (issue_ready !== 1'b0) begin n_err++; $display("FAIL var_stall c%0d: got %b exp 0", c, issue_ready); end
      n_vec++; if (flush !== 5'b00100) begin n_err++; $display("FAIL var_bubble c%0d: got %b exp 00100", c, flush); end
      tick();
    end
    wb_valid = 1; wb_reg = 5'd7;
    #1;
    n_vec++; if (fwd_rt !== 1'b1) begin n_err++; $display("FAIL var_fwd_rt: got %b exp 1", fwd_rt); end
    n_vec++; if (fwd_rs !== 1'b0) begin n_err++; $display("FAIL var_fwd_rs: got %b exp 0", fwd_rs); end
    n_vec++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL var_ready: got %b exp 1", issue_ready); end
    tick();
    idle_inputs();
    #1;
    n_vec++; if (dbg_pend !== 32'h0) begin n_err++; $display("FAIL var_cleared: got %h exp 0", dbg_pend); end
  endtask

  // r0 is never tracked: writes to it and reads of it never stall.
  task automatic test_r0();
    for (int c = 0; c < 2; c++) begin
      idle_inputs();
      issue_valid = 1; issue_rs_used = 1; issue_rt_used = 1;
      issue_wen = 1; issue_wreg = 0; issue_lat = 3'd3;
      #1;
      n_vec++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL r0_ready c%0d: got %b exp 1", c, issue_ready); end
      n_vec++; if ({fwd_rs, fwd_rt} !== 2'b00) begin n_err++; $display("FAIL r0_fwd c%0d: got %b exp 00", c, {fwd_rs, fwd_rt}); end
      n_vec++; if (flush !== 5'b00000) begin n_err++; $display("FAIL r0_flush c%0d: got %b exp 00000", c, flush); end
      tick();
      #1;
      n_vec++; if (dbg_pend !== 32'h0) begin n_err++; $display("FAIL r0_pend c%0d: got %h exp 0", c, dbg_pend); end
    end
  endtask

  // Write-after-write to r3, reload on the retiring cycle.
  task automatic test_waw();
    drive_write(5'd3, 3'd2);
    tick();
    drive_write(5'd3, 3'd1);
    #1;
    n_vec++; if (issue_ready !== 1'b0) begin n_err++; $display("FAIL waw_stall: got %b exp 0", issue_ready); end
    n_vec++; if (flush !== 5'b00100) begin n_err++; $display("FAIL waw_bubble: got %b exp 00100", flush); end
    tick();
    #1;
    n_vec++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL waw_reload: got %b exp 1", issue_ready); end
    tick();
    drive_use_rs(5'd3);
    #1;
    n_vec++; if (fwd_rs !== 1'b1) begin n_err++; $display("FAIL waw_fwd: got %b exp 1", fwd_rs); end
    n_vec++; if (dbg_pend !== 32'h0000_0008) begin n_err++; $display("FAIL waw_pend: got %h exp 00000008", dbg_pend); end
    tick();
    idle_inputs();
    #1;
    n_vec++; if (dbg_pend !== 32'h0) begin n_err++; $display("FAIL waw_cleared: got %h exp 0", dbg_pend); end
  endtask

  // Instruction memory stall: no acceptance, and no E bubble on a hazard.
  task automatic test_stall_imem();
    drive_use_rs(5'd1);
    stall_imem = 1;
    #1;
    n_vec++; if (issue_ready !== 1'b0) begin n_err++; $display("FAIL imem_ready: got %b exp 0", issue_ready); end
    n_vec++; if (stallF !== 1'b1) begin n_err++; $display("FAIL imem_stallF: got %b exp 1", stallF); end
    n_vec++; if (flush !== 5'b00000) begin n_err++; $display("FAIL imem_flush: got %b exp 00000", flush); end
    drive_write(5'd2, 3'd0);
    tick();
    drive_use_rs(5'd2);
    stall_imem = 1;
    #1;
    n_vec++; if (flush !== 5'b00000) begin n_err++; $display("FAIL imem_haz_flush: got %b exp 00000", flush); end
    tick();
    stall_imem = 0; wb_valid = 1; wb_reg = 5'd2;
    #1;
    n_vec++; if ({issue_ready, fwd_rs} !== 2'b11) begin n_err++; $display("FAIL imem_release: got %b exp 11", {issue_ready, fwd_rs}); end
    tick();
    idle_inputs();
  endtask

  task automatic test_exception();
    drive_write(5'd4, 3'd0);
    tick();
    // Exception cycle, with a consumer and a writeback to r4 also present.
    drive_use_rs(5'd4);
    wb_valid = 1; wb_reg = 5'd4; except_valid = 1; excepttype = 32'h0C;
    #1;
    n_vec++; if (flush !== 5'b11111) begin n_err++; $display("FAIL exc_flush: got %b exp 11111", flush); end
    n_vec++; if (issue_ready !== 1'b0) begin n_err++; $display("FAIL exc_ready: got %b exp 0", issue_ready); end
    n_vec++; if (newpc_valid !== 1'b0) begin n_err++; $display("FAIL exc_pcv0: got %b exp 0", newpc_valid); end
    tick();
    idle_inputs();
    stall_imem = 1;
    #1;
    n_vec++; if (newpc !== 32'hBFC00380) begin n_err++; $display("FAIL exc_newpc: got %h exp bfc00380", newpc); end
    n_vec++; if (newpc_valid !== 1'b1) begin n_err++; $display("FAIL exc_pcv1: got %b exp 1", newpc_valid); end
    n_vec++; if (flush !== 5'b00011) begin n_err++; $display("FAIL exc_redir_flush: got %b exp 00011", flush); end
    n_vec++; if (stallF !== 1'b1) begin n_err++; $display("FAIL exc_stallF: got %b exp 1", stallF); end
    n_vec++; if (dbg_pend !== 32'h0) begin n_err++; $display("FAIL exc_sb_clear: got %h exp 0", dbg_pend); end
    n_vec++; if (dbg_state !== 1'b1) begin n_err++; $display("FAIL exc_state: got %b exp 1", dbg_state); end
    tick();
    // A second exception during redirect is ignored.
    stall_imem = 1; except_valid = 1; excepttype = 32'h0E; epc = 32'h80001234;
    #1;
    n_vec++; if (flush !== 5'b00011) begin n_err++; $display("FAIL exc_ignore_flush: got %b exp 00011", flush); end
    n_vec++; if (newpc_valid !== 1'b1) begin n_err++; $display("FAIL exc_pcv2: got %b exp 1", newpc_valid); end
    tick();
    idle_inputs();
    #1;
    n_vec++; if ({newpc_valid, newpc} !== {1'b1, 32'hBFC00380}) begin n_err++; $display("FAIL exc_pcv3: got %b/%h exp 1/bfc00380", newpc_valid, newpc); end
    tick();
    #1;
    n_vec++; if (newpc_valid !== 1'b0) begin n_err++; $display("FAIL exc_done_pcv: got %b exp 0", newpc_valid); end
    n_vec++; if (dbg_state !== 1'b0) begin n_err++; $display("FAIL exc_done_state: got %b exp 0", dbg_state); end
    n_vec++; if ({stallF, flush} !== 6'b0) begin n_err++; $display("FAIL exc_done_quiet: got %b/%b exp 0/00000", stallF, flush); end
    // eret returns to epc.
    except_valid = 1; excepttype = 32'h0E; epc = 32'h80001234;
    #1;
    n_vec++; if (flush !== 5'b11111) begin n_err++; $display("FAIL eret_flush: got %b exp 11111", flush); end
    tick();
    idle_inputs();
    #1;
    n_vec++; if ({newpc_valid, newpc} !== {1'b1, 32'h80001234}) begin n_err++; $display("FAIL eret_newpc: got %b/%h exp 1/80001234", newpc_valid, newpc); end
    tick();
    #1;
    n_vec++; if (newpc_valid !== 1'b0) begin n_err++; $display("FAIL eret_done: got %b exp 0", newpc_valid); end
    // excepttype 0 is not an exception.
    drive_use_rs(5'd1);
    except_valid = 1; excepttype = 32'h0;
    #1;
    n_vec++; if ({issue_ready, flush} !== 6'b0) begin n_err++; $display("FAIL exc0_quiet: got %b/%b exp 0/00000", issue_ready, flush); end
    tick();
    idle_inputs();
    #1;
    n_vec++; if ({dbg_state, newpc_valid} !== 2'b00) begin n_err++; $display("FAIL exc0_idle: got %b exp 00", {dbg_state, newpc_valid}); end
  endtask

  // Same-cycle writeback and reload of r9, then async reset mid-stall.
  task automatic test_back_to_back();
    drive_write(5'd9, 3'd0);
    tick();
    drive_write(5'd9, 3'd2);
    wb_valid = 1; wb_reg = 5'd9;
    #1;
    n_vec++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL b2b_reload: got %b exp 1", issue_ready); end
    tick();
    drive_use_rs(5'd9);
    #1;
    n_vec++; if (issue_ready !== 1'b0) begin n_err++; $display("FAIL b2b_still_pend: got %b exp 0", issue_ready); end
    n_vec++; if (dbg_pend !== 32'h0000_0200) begin n_err++; $display("FAIL b2b_pend1: got %h exp 00000200", dbg_pend); end
    tick();
    #1;
    n_vec++; if ({fwd_rs, issue_ready} !== 2'b11) begin n_err++; $display("FAIL b2b_fwd: got %b exp 11", {fwd_rs, issue_ready}); end
    n_vec++; if (dbg_pend !== 32'h0000_0200) begin n_err++; $display("FAIL b2b_pend2: got %h exp 00000200", dbg_pend); end
    tick();
    #1;
    n_vec++; if (dbg_pend !== 32'h0) begin n_err++; $display("FAIL b2b_cleared: got %h exp 0", dbg_pend); end
    // Reset asserted between edges while a consumer is stalled.
    drive_write(5'd11, 3'd0);
    tick();
    drive_use_rs(5'd11);
    #1;
    n_vec++; if (issue_ready !== 1'b0) begin n_err++; $display("FAIL rst_mid_pre: got %b exp 0", issue_ready); end
    resetn = 0;
    #1;
    n_vec++; if (dbg_pend !== 32'h0) begin n_err++; $display("FAIL rst_mid_pend: got %h exp 0", dbg_pend); end
    n_vec++; if ({stallF, issue_ready, flush} !== 7'b0) begin n_err++; $display("FAIL rst_mid_quiet: got %b/%b/%b exp 0/0/00000", stallF, issue_ready, flush); end
    n_vec++; if (newpc !== 32'h0) begin n_err++; $display("FAIL rst_mid_newpc: got %h exp 0", newpc); end
    #1 resetn = 1;
    tick();
    #1;
    n_vec++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_after: got %b exp 1", issue_ready); end
    tick();
    idle_inputs();
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_fixed_lat();
    test_var_lat();
    test_r0();
    test_waw();
    test_stall_imem();
    test_exception();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter NREG, default 32: number of architectural registers; register 0 is never tracked.
REQ-002 Parameter LAT_W, default 3: width of the latency counter; issue_lat 0 means variable latency.
REQ-003 Parameter NSTAGE, default 5: width of the flush vector; bit0=F, bit1=D, bit2=E, bit3=M, bit4=W.
REQ-004 Parameter EXC_VECTOR, default 32'hBFC00380: target PC for every nonzero excepttype except 32'h0E.
REQ-005 Ports, one per line (name, direction, width, meaning):
  clk  in  1  single clock, rising edge.
  resetn  in  1  asynchronous, active-low reset.
  issue_valid  in  1  decode-stage instruction present.
  issue_rs, issue_rt  in  log2(NREG)  source registers.
  issue_rs_used, issue_rt_used  in  1  source is actually read.
  issue_wen  in  1  instruction writes a register.
  issue_wreg  in  log2(NREG)  destination register.
  issue_lat  in  LAT_W  cycles until the result is on the bypass; 0 = variable.
  wb_valid  in  1  variable-latency result completes this cycle.
  wb_reg  in  log2(NREG)  register completed by wb_valid.
  stall_imem  in  1  instruction memory not ready.
  except_valid  in  1  exception or eret committed in M.
  excepttype  in  32  exception code.
  epc  in  32  return PC for eret.
  issue_ready  out  1  instruction accepted this cycle.
  fwd_rs, fwd_rt  out  1  take the operand from the bypass this cycle.
  stallF, stallD  out  1  hold the PC / IF-ID register.
  flush  out  NSTAGE  per-stage flush.
  newpc  out  32  redirect target.
  newpc_valid  out  1  redirect request.

Function
REQ-006 Per-register state is pend[r] (1 bit) and cnt[r] (LAT_W bits); r=0 always reads pend=0.
REQ-007 Accept = issue_valid & issue_ready.
  - On accept with issue_wen and issue_wreg!=0: pend<=1, cnt<=issue_lat at the next edge.
REQ-008 Fixed-latency entry (pend=1, cnt>=2) decrements cnt by 1 per cycle.
  - When cnt==1: the entry is "retiring", and at the next edge pend<=0, cnt<=0.
REQ-009 Variable-latency entry (pend=1, cnt==0) clears only on wb_valid with wb_reg==r; it is "retiring" in that cycle.
REQ-010 A new accepted write to r in the same cycle as r retires or is written back takes priority: the entry is reloaded, not cleared.
REQ-011 RAW hazard: a used source s!=0 with pend[s]=1 that is not retiring this cycle.
REQ-012 fwd_rs (fwd_rt) = issue_valid & source used & source retiring this cycle; otherwise 0.
REQ-013 WAW hazard: issue_wen & issue_wreg!=0 & pend[issue_wreg]=1 & not retiring.
REQ-014 issue_ready = issue_valid & !RAW & !WAW & !stall_imem & state==IDLE & !except_valid.
REQ-015 stallF = stallD = issue_valid & !issue_ready, or stall_imem, or state==REDIRECT.
REQ-016 When a RAW or WAW hazard exists and stall_imem=0 and no exception: flush[2]=1 (E bubble); other flush bits are 0.
REQ-017 Recovery FSM has two states, IDLE and REDIRECT.
  - IDLE with except_valid & excepttype!=0: flush all ones that cycle.
  - In the same cycle, capture newpc (epc if excepttype==32'h0E, else EXC_VECTOR) and clear every pend/cnt at the next edge.
  - Then go to REDIRECT.
REQ-018 REDIRECT:
  - newpc_valid=1 and flush[1:0]=2'b11.
  - Hold while stall_imem=1.
  - Return to IDLE on the first cycle with stall_imem=0; newpc_valid is high in that cycle.
REQ-019 except_valid in REDIRECT is ignored; excepttype==0 with except_valid=1 is treated as no exception.
REQ-020 Any exception clears the scoreboard; a wb_valid in that same cycle has no further effect.

Reset
REQ-021 While resetn=0, all of the following hold, and no transition occurs until the first edge after deassertion:
  - All pend/cnt are 0 and state is IDLE.
  - newpc=0 and newpc_valid=0.
  - flush=0, stallF=stallD=0, issue_ready=0.

Verification
REQ-022 Issue wreg=5 with lat=3, then consumer rs=5 every cycle:
  - issue_ready=0 for 2 cycles.
  - Third cycle: fwd_rs=1 and issue_ready=1.
  - flush[2]=1 on each stall cycle.
REQ-023 Issue wreg=7 with lat=0, consumer rt=7: stalled until wb_valid/wb_reg=7 arrives; in that cycle fwd_rt=1 and issue_ready=1.
REQ-024 Consumer of r0 and writer to r0: never stalls, fwd=0, pend[0] stays 0.
REQ-025 Exceptions with stall_imem=1 for 2 cycles:
  - excepttype=32'h0C gives flush=5'b11111 for one cycle, then newpc=32'hBFC00380 with newpc_valid=1 for 3 cycles, then IDLE with the scoreboard empty.
  - excepttype=32'h0E with epc=32'h80001234 gives newpc=32'h80001234.
REQ-026 Variable write to r9 pending:
  - wb_valid/wb_reg=9 and a new lat=2 issue to r9 in the same cycle leave r9 pending for 2 more cycles.
  - resetn=0 mid-stall clears everything asynchronously.
